// File: rtl/ultrasonic_filter.sv
// Ultrasonic echo filter: rejects out-of-range echo widths, takes a moving average,
// converts it to centimetres and raises a hysteretic near-obstacle flag for a Nios CPU.
module ultrasonic_filter #(
    parameter int DEPTH     = 4,
    parameter int MAX_COUNT = 1_200_000,
    parameter int CM_MULT   = 362,
    parameter int NEAR_CM   = 20,
    parameter int HYST_CM   = 5
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic [31:0] sample_data,
    input  logic        sample_valid,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avg_valid,
    output logic        obstacle
);
    localparam int SH = $clog2(DEPTH);

    logic        accept;
    logic        reject;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] smp_buf [DEPTH];
    logic [SH-1:0] wr_ptr;
    logic [33:0] sum;
    logic [7:0]  fill;
    logic [31:0] avg;
    logic        avg_ok;
    logic [15:0] distance_cm;
    logic        dist_ok;
    logic [15:0] reject_cnt;

    assign accept    = sample_valid && (sample_data != 32'd0) && (sample_data <= 32'(MAX_COUNT));
    assign reject    = sample_valid && !accept;
    assign avg_valid = (fill == 8'(DEPTH));

    // Register accepted samples first so the window update is off the input path.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            in_valid <= 1'b0;
            in_data  <= '0;
        end else begin
            in_valid <= accept;
            in_data  <= accept ? sample_data : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < DEPTH; i++) smp_buf[i] <= '0;
            wr_ptr <= '0;
            sum    <= '0;
            fill   <= '0;
        end else if (in_valid) begin
            smp_buf[wr_ptr] <= in_data;
            sum    <= sum + 34'(in_data) - 34'(smp_buf[wr_ptr]);
            wr_ptr <= (wr_ptr == SH'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (fill != 8'(DEPTH)) fill <= fill + 8'd1;
        end
    end

    // ok flags trail the data so a partly filled window never reaches distance/obstacle.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            avg         <= '0;
            avg_ok      <= 1'b0;
            distance_cm <= '0;
            dist_ok     <= 1'b0;
            obstacle    <= 1'b0;
        end else begin
            avg         <= 32'(sum >> SH);
            avg_ok      <= avg_valid;
            distance_cm <= avg_ok ? 16'((64'(avg) * 64'(CM_MULT)) >> 20) : 16'd0;
            dist_ok     <= avg_ok;
            if (!dist_ok)
                obstacle <= 1'b0;
            else if (distance_cm < 16'(NEAR_CM))
                obstacle <= 1'b1;
            else if (distance_cm >= 16'(NEAR_CM + HYST_CM))
                obstacle <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            reject_cnt <= '0;
        end else if (avs_read && avs_address == 2'd3) begin
            reject_cnt <= reject ? 16'd1 : 16'd0;
        end else if (reject && reject_cnt != 16'hFFFF) begin
            reject_cnt <= reject_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            case (avs_address)
                2'd0:    avs_readdata <= {16'b0, distance_cm};
                2'd1:    avs_readdata <= avg;
                2'd2:    avs_readdata <= {16'b0, fill, 6'b0, obstacle, avg_valid};
                default: avs_readdata <= {16'b0, reject_cnt};
            endcase
        end
    end
endmodule

// File: tb/tb_ultrasonic_filter.sv
// Bench for ultrasonic_filter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a window-average model with spec latencies.
module tb_ultrasonic_filter;
    localparam int DEPTH = 4;
    localparam int MAXC  = 1_200_000;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic [31:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avg_valid;
    logic        obstacle;

    int n_cmp = 0;
    int n_bad = 0;

    ultrasonic_filter dut (
        .clk(clk), .reset_l(reset_l), .sample_data(sample_data), .sample_valid(sample_valid),
        .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
        .avg_valid(avg_valid), .obstacle(obstacle)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint unsigned win[$];
    longint unsigned hs[5];
    int              hc[5];
    logic [31:0] m_rd = '0;
    logic [15:0] m_rej = '0;
    logic [7:0]  m_fill = '0;
    logic        m_avgv = 1'b0;
    logic [31:0] m_avg = '0;
    logic [15:0] m_dist = '0;
    logic        m_obs = 1'b0;

    function automatic logic [15:0] to_cm(input longint unsigned a);
        longint unsigned p;
        p = (a * 64'd362) >> 20;
        return p[15:0];
    endfunction

    always @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            win.delete();
            for (int i = 0; i < 5; i++) begin hs[i] = 0; hc[i] = 0; end
            m_rd = '0; m_rej = '0; m_fill = '0; m_avgv = 1'b0;
            m_avg = '0; m_dist = '0; m_obs = 1'b0;
        end else begin
            logic acc, rej;
            longint unsigned s;
            acc = sample_valid && sample_data != 0 && sample_data <= MAXC;
            rej = sample_valid && !acc;
            if (avs_read) begin
                case (avs_address)
                    2'd0: m_rd = {16'b0, m_dist};
                    2'd1: m_rd = m_avg;
                    2'd2: m_rd = {16'b0, m_fill, 6'b0, m_obs, m_avgv};
                    default: m_rd = {16'b0, m_rej};
                endcase
            end
            if (avs_read && avs_address == 2'd3) m_rej = rej ? 16'd1 : 16'd0;
            else if (rej && m_rej != 16'hFFFF) m_rej = m_rej + 16'd1;
            if (acc) begin
                win.push_back(sample_data);
                if (win.size() > DEPTH) void'(win.pop_front());
            end
            s = 0;
            foreach (win[i]) s += win[i];
            for (int k = 4; k > 0; k--) begin hs[k] = hs[k-1]; hc[k] = hc[k-1]; end
            hs[0] = s; hc[0] = win.size();
            // hs/hc[k]: window state including samples accepted k edges ago
            if (hc[4] != DEPTH) m_obs = 1'b0;
            else if (m_dist < 16'd20) m_obs = 1'b1;
            else if (m_dist >= 16'd25) m_obs = 1'b0;
            m_fill = 8'(hc[1]);
            m_avgv = (hc[1] == DEPTH);
            m_avg  = 32'(hs[2] / DEPTH);
            m_dist = (hc[3] == DEPTH) ? to_cm(hs[3] / DEPTH) : 16'd0;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_l) begin
            check("model_readdata", avs_readdata, m_rd);
            check("model_avg_valid", {31'b0, avg_valid}, {31'b0, m_avgv});
            check("model_obstacle", {31'b0, obstacle}, {31'b0, m_obs});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic [1:0] a);
        sample_valid = v; sample_data = d; avs_read = r; avs_address = a;
        @(posedge clk); #1;
        sample_valid = 1'b0; sample_data = '0; avs_read = 1'b0; avs_address = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 2'd0);
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
        step(1'b0, 32'd0, 1'b1, a);
        check(name, avs_readdata, exp);
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_l = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();
        check("reset_readdata", avs_readdata, 32'd0);
        check("reset_avg_valid", {31'b0, avg_valid}, 32'd0);
        check("reset_obstacle", {31'b0, obstacle}, 32'd0);

        for (int i = 0; i < 4; i++) step(1'b1, 32'd29000, 1'b0, 2'd0);
        idle(4);
        check("avg_valid_after_4", {31'b0, avg_valid}, 32'd1);
        check("obstacle_near", {31'b0, obstacle}, 32'd1);
        rd_chk(2'd1, 32'd29000, "avg_29000");
        rd_chk(2'd0, 32'd10, "dist_10");

        step(1'b1, 32'd87000, 1'b0, 2'd0);
        idle(4);
        rd_chk(2'd1, 32'd43500, "avg_43500");
        rd_chk(2'd0, 32'd15, "dist_15");
        check("obstacle_hold", {31'b0, obstacle}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'd87000, 1'b0, 2'd0);
        idle(4);
        rd_chk(2'd1, 32'd87000, "avg_87000");
        rd_chk(2'd0, 32'd30, "dist_30");
        check("obstacle_clear", {31'b0, obstacle}, 32'd0);

        step(1'b1, 32'd0, 1'b0, 2'd0);
        step(1'b1, 32'd2_000_000, 1'b0, 2'd0);
        step(1'b1, 32'd1_200_001, 1'b0, 2'd0);
        idle(4);
        rd_chk(2'd1, 32'd87000, "avg_after_reject");
        rd_chk(2'd2, 32'h0000_0401, "status_after_reject");
        rd_chk(2'd3, 32'd3, "reject_cnt_3");
        rd_chk(2'd3, 32'd0, "reject_cnt_cleared");

        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'd58000, 1'b0, 2'd0);
        idle(4);
        rd_chk(2'd2, 32'h0000_0401, "status_58000");
        rd_chk(2'd1, 32'd58000, "avg_58000");
        rd_chk(2'd0, 32'd20, "dist_20_threshold");
        check("obstacle_at_threshold", {31'b0, obstacle}, 32'd0);

        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'd40000, 1'b0, 2'd0);
        do_reset();
        check("midreset_avg_valid", {31'b0, avg_valid}, 32'd0);
        rd_chk(2'd2, 32'd0, "midreset_status");
        for (int i = 0; i < 3; i++) step(1'b1, 32'd40000, 1'b0, 2'd0);
        idle(4);
        check("three_after_reset", {31'b0, avg_valid}, 32'd0);
        rd_chk(2'd2, 32'h0000_0300, "status_fill3");
        step(1'b1, 32'd1_200_000, 1'b0, 2'd0);
        idle(4);
        rd_chk(2'd1, 32'd330000, "avg_max_count_accepted");

        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, (i % 2) ? 32'd3_000_000 : 32'd0, 1'b0, 2'd0);
        step(1'b1, 32'd0, 1'b1, 2'd3);
        check("clear_with_reject", avs_readdata, 32'd5);
        rd_chk(2'd3, 32'd1, "reject_after_clear");

        for (int c = 0; c < 4000; c++) begin
            logic [31:0] d;
            int sel;
            if ($urandom_range(0, 499) == 0) do_reset();
            sel = $urandom_range(0, 19);
            if (sel == 0) d = 32'd0;
            else if (sel == 1) d = 32'(MAXC + 1 + $urandom_range(0, 5000));
            else if (sel == 2) d = 32'(MAXC);
            else d = 32'($urandom_range(30000, 100000));
            step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ultrasonic_filter.md
ULTRASONIC_FILTER -- requirements
Module: ultrasonic_filter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the moving-average window in samples (power of two, 2..16).
REQ-002 Parameter MAX_COUNT, default 1_200_000, SHALL be the largest accepted echo count in clocks.
REQ-003 Parameter CM_MULT, default 362, SHALL be the count-to-cm scale: distance_cm = (avg * CM_MULT) >> 20.
REQ-004 Parameter NEAR_CM, default 20, SHALL be the obstacle set threshold in cm.
REQ-005 Parameter HYST_CM, default 5, SHALL be the obstacle clear hysteresis in cm.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 reset_l  in  1  asynchronous, active-low reset.
REQ-008 sample_data  in  32  echo pulse width in clocks, from the upstream ultra_sonic read_data.
REQ-009 sample_valid  in  1  one-cycle strobe qualifying sample_data, from upstream read_data_valid.
REQ-010 avs_address  in  2  Nios register select.
REQ-011 avs_read  in  1  Nios read strobe.
REQ-012 avs_readdata  out  32  registered read data.
REQ-013 avg_valid  out  1  high once DEPTH samples have been accepted.
REQ-014 obstacle  out  1  hysteretic near-object flag.

Function
REQ-015 Sample with sample_valid=1 and (sample_data==0 or sample_data>MAX_COUNT) SHALL be rejected: buffer, sum, fill unchanged; reject_cnt incremented.
REQ-016 reject_cnt SHALL be 16 bits, saturating at 16'hFFFF.
REQ-017 Accepted sample SHALL be written to a DEPTH-entry circular buffer at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
REQ-018 Running sum (34 bits) SHALL update in the accept cycle: sum <= sum + new - buf[wr_ptr] (zero until slot first written).
REQ-019 fill SHALL count accepted samples, saturating at DEPTH; avg_valid = (fill==DEPTH).
REQ-020 Samples SHALL be accepted back-to-back on consecutive cycles with no loss.
REQ-021 Stage 2: avg <= sum >> log2(DEPTH) (32 bits), one cycle after sum update.
REQ-022 Stage 3: distance_cm <= (avg * CM_MULT) >> 20, truncated to 16 bits, one cycle after avg.
REQ-023 Latency: sample_valid at edge N -> avg visible N+2, distance_cm N+3, obstacle N+4.
REQ-024 While avg_valid=0, distance_cm and obstacle SHALL hold 0.
REQ-025 obstacle SHALL set when avg_valid and distance_cm<NEAR_CM; clear when distance_cm>=NEAR_CM+HYST_CM; otherwise hold.
REQ-026 Register map (read on avs_read, avs_readdata valid next cycle, held otherwise): 0 = {16'b0, distance_cm}; 1 = avg; 2 = {fill[7:0] at [15:8], 6'b0, obstacle at [1], avg_valid at [0]} upper bits 0; 3 = {16'b0, reject_cnt}.
REQ-027 Reading address 3 SHALL clear reject_cnt; simultaneous read-clear and new reject SHALL leave reject_cnt=1 and return the pre-clear value.
REQ-028 Read to any address SHALL have no other side effect.

Reset
REQ-029 reset_l low SHALL immediately clear buffer, sum, wr_ptr, fill, avg, distance_cm, reject_cnt, obstacle, avg_valid and avs_readdata to 0.
REQ-030 Reset asserted mid-stream SHALL discard all samples; after release, avg_valid needs DEPTH new accepted samples.

Verification
REQ-031 Reset, four samples 29000 -> avg_valid=1 after 4th, avg=29000, distance_cm=10, obstacle=1 at N+4.
REQ-032 Then one sample 87000 -> avg=43500, distance_cm=15, obstacle stays 1; three more 87000 -> avg=87000, distance_cm=30, obstacle=0.
REQ-033 Samples 0 and 2_000_000 -> reject_cnt=2, avg/fill unchanged; read addr 3 returns 2, then reads 0.
REQ-034 Four 58000 samples on consecutive cycles -> fill=4, avg=58000, distance_cm=20, obstacle=0 from reset state.
REQ-035 Three accepted samples, reset_l pulsed low -> all outputs 0, addr 2 reads 0; three more samples -> avg_valid still 0.
REQ-036 Read addr 3 in same cycle as a reject with reject_cnt=5 -> returns 5, next read returns 1.
